sram_arbiter: RTL

Two-port arbiter and sequencer for the external 16-bit asynchronous SRAM (18-bit halfword address, 512 KB). It sits between the core-side requesters (port 0: LSU data access; port 1: a secondary master such as a program loader or debug port) and the SRAM pins. It grants one requester at a time with round-robin fairness and splits each 32-bit word access into two 16-bit SRAM phases. It drives CE/OE/WE/LB/UB and the tri-state data bus with registered timing.

---
 rtl/sram_arbiter_if.sv | 13 +
 rtl/sram_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for the two-port SRAM arbiter: port 0 is the LSU, port 1 the secondary master.
interface sram_arbiter_if;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [1:0][18:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0][3:0]  bmask;
  logic [1:0]       ack;
  logic [1:0][31:0] rdata;

  modport master (output req, we, addr, wdata, bmask, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, bmask, output ack, rdata);
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter that splits each 32-bit access into two 16-bit async SRAM phases.
// Every SRAM pin and ack is a register, so no combinational path exists from req to any output.
module sram_arbiter #(
  parameter int PHASE_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sram_arbiter_if.slave bus,
  output logic        o_busy,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);
  localparam int            CW       = $clog2(PHASE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYC - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [16:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       bmask_q, bmask_d;
  logic [15:0]      lo_q;
  logic [1:0][31:0] rdata_q;
  logic [1:0]       ack_q, ack_d;
  logic             ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q;
  logic             ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d;
  logic [17:0]      sram_addr_q, sram_addr_d;
  logic             dq_oe_q, dq_oe_d;
  logic [15:0]      dq_out_q, dq_out_d;
  logic             cnt_last, phase_d, hi_d;
  logic [1:0]       half_mask_d;
  logic             unused_addr_lsbs;

  assign cnt_last         = (cnt_q == CNT_LAST);
  assign unused_addr_lsbs = ^{bus.addr[0][1:0], bus.addr[1][1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|bus.req) begin
          // On a tie the port not granted last wins; a lone requester always wins.
          gnt_d   = (&bus.req) ? ~gnt_q : bus.req[1];
          state_d = LO;
          we_d    = bus.we[gnt_d];
          addr_d  = bus.addr[gnt_d][18:2];
          wdata_d = bus.wdata[gnt_d];
          bmask_d = bus.bmask[gnt_d];
        end
      end
      LO: begin
        cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        if (cnt_last) state_d = HI;
      end
      HI: begin
        cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        if (cnt_last) state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pins are computed from the next state so they line up with the state register.
  always_comb begin
    phase_d     = (state_d == LO) || (state_d == HI);
    hi_d        = (state_d == HI);
    half_mask_d = hi_d ? bmask_d[3:2] : bmask_d[1:0];
    ce_n_d      = ~phase_d;
    oe_n_d      = ~(phase_d & ~we_d);
    // WE rises one cycle before the phase ends so data is held past the rising edge.
    we_n_d      = ~(phase_d & we_d & (cnt_d != CNT_LAST));
    lb_n_d      = phase_d ? (we_d & ~half_mask_d[0]) : 1'b1;
    ub_n_d      = phase_d ? (we_d & ~half_mask_d[1]) : 1'b1;
    sram_addr_d = phase_d ? {addr_d, hi_d} : sram_addr_q;
    dq_oe_d     = phase_d & we_d;
    dq_out_d    = hi_d ? wdata_d[31:16] : wdata_d[15:0];
    ack_d       = (state_d == DONE) ? (2'b01 << gnt_d) : 2'b00;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bmask_q     <= '0;
      lo_q        <= '0;
      rdata_q     <= '0;
      ack_q       <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      sram_addr_q <= '0;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bmask_q     <= bmask_d;
      ack_q       <= ack_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      sram_addr_q <= sram_addr_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
      if (state_q == LO && cnt_last && !we_q) lo_q <= SRAM_DQ;
      if (state_q == HI && cnt_last && !we_q) rdata_q[gnt_q] <= {SRAM_DQ, lo_q};
    end
  end

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign o_busy    = (state_q != IDLE);
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
endmodule
